// File: rtl/hammer_test_pkg.sv
// Shared types and helpers for the rowhammer trial engine.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package hammer_test_pkg;

   // Trial sequencing states
   typedef enum logic [2:0] {
      IDLE,
      INIT,
      HAMMER,
      CHECK,
      CHECK_WAIT,
      DONE
   } state_t;

   // Aggressor selection modes
   localparam logic MODE_DOUBLE = 1'b0;
   localparam logic MODE_SINGLE = 1'b1;

   // Place row and column fields into a bus address; all other bits zero.
   // Callers pass already-masked fields and truncate the result to their bus width.
   function automatic logic [63:0] pack_addr(input logic [63:0]   row,
                                             input logic [63:0]   col,
                                             input int unsigned   row_pos,
                                             input int unsigned   col_pos);
      return (row << row_pos) | (col << col_pos);
   endfunction

endpackage

// File: rtl/hammer_test_engine_popcount_tree.sv
// Counts set bits of a word; used to score flipped bits per read-back word.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module popcount_tree #(
   parameter  int WORD_WIDTH = 64,
   localparam int CNT_W      = $clog2(WORD_WIDTH) + 1
) (
   input  logic [WORD_WIDTH-1:0] data_i,
   output logic [CNT_W-1:0]      count_o
);

   // Bitwise sum; synthesis rebalances the chain into an adder tree
   always_comb begin
      count_o = '0;
      for (int i = 0; i < WORD_WIDTH; i++) begin
         count_o = count_o + CNT_W'(data_i[i]);
      end
   end

endmodule

// File: rtl/hammer_test_engine.sv
// One rowhammer trial per start: write victim row, hammer aggressors, read back, count flips.
// Latency: one request per accepted cycle; each read waits for its data before the next.
// Backpressure: avm_waitrequest holds address/command/data; one read outstanding at a time.
// Optional flip logging (first flip column/mask, flipped-word count) under HAMMER_TEST_FLIP_LOG_EN.
module hammer_test_engine
   import hammer_test_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int WORD_WIDTH     = 64,
   parameter int ROW_WIDTH      = 12,
   parameter int ROW_POS        = 10,
   parameter int COL_WIDTH      = 10,
   parameter int COL_POS        = 0,
   parameter int FAR_ROW_OFFSET = 64,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ROW_WIDTH-1:0]  cfg_row,
   input  logic                  cfg_mode,
   input  logic [WORD_WIDTH-1:0] cfg_pattern,
   input  logic [CNT_WIDTH-1:0]  cfg_count,
   output logic [ADDR_WIDTH-1:0] avm_address,
   output logic                  avm_read,
   output logic                  avm_write,
   output logic [WORD_WIDTH-1:0] avm_writedata,
   input  logic                  avm_waitrequest,
   input  logic [WORD_WIDTH-1:0] avm_readdata,
   input  logic                  avm_readdatavalid,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_WIDTH-1:0]  flip_count
`ifdef HAMMER_TEST_FLIP_LOG_EN
   ,
   output logic [COL_WIDTH-1:0]  first_flip_col,
   output logic [WORD_WIDTH-1:0] first_flip_mask,
   output logic [COL_WIDTH:0]    flip_words
`endif
);

   localparam int POP_W = $clog2(WORD_WIDTH) + 1;
   localparam logic [ROW_WIDTH-1:0] FAR_OFF = ROW_WIDTH'(FAR_ROW_OFFSET);

   state_t                  state_q;
   logic [ROW_WIDTH-1:0]    row_q;
   logic                    mode_q;
   logic [WORD_WIDTH-1:0]   pattern_q;
   logic [CNT_WIDTH-1:0]    count_q;
   logic [COL_WIDTH-1:0]    col_q;
   logic [CNT_WIDTH-1:0]    hcnt_q;
   logic                    side_q;      // 0: next hammer read goes to A, 1: to B
   logic                    wait_q;      // hammer read accepted, data not yet back
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    rd_q;
   logic                    wr_q;
   logic [WORD_WIDTH-1:0]   wdata_q;
   logic                    busy_q;
   logic                    done_q;
   logic [CNT_WIDTH-1:0]    flip_q;
   logic [CNT_WIDTH-1:0]    flip_d;
`ifdef HAMMER_TEST_FLIP_LOG_EN
   logic [COL_WIDTH-1:0]    ffcol_q;
   logic [WORD_WIDTH-1:0]   ffmask_q;
   logic [COL_WIDTH:0]      fwords_q;
`endif

   logic [WORD_WIDTH-1:0]   xor_w;
   logic [POP_W-1:0]        pop_w;
   logic [CNT_WIDTH:0]      sum_w;
   logic [ROW_WIDTH-1:0]    agg_a_w;
   logic [ROW_WIDTH-1:0]    agg_b_w;
   logic                    accept_w;
   logic                    col_last_w;

   function automatic logic [ADDR_WIDTH-1:0] mk_addr(input logic [ROW_WIDTH-1:0] r,
                                                     input logic [COL_WIDTH-1:0] c);
      return ADDR_WIDTH'(pack_addr(64'(r), 64'(c), ROW_POS, COL_POS));
   endfunction

   assign xor_w      = avm_readdata ^ pattern_q;
   assign sum_w      = {1'b0, flip_q} + (CNT_WIDTH + 1)'(pop_w);
   assign flip_d     = sum_w[CNT_WIDTH] ? '1 : sum_w[CNT_WIDTH-1:0];
   assign agg_a_w    = (mode_q == MODE_SINGLE) ? row_q + 1'b1 : row_q - 1'b1;
   assign agg_b_w    = (mode_q == MODE_SINGLE) ? row_q + FAR_OFF : row_q + 1'b1;
   assign accept_w   = (rd_q | wr_q) & ~avm_waitrequest;
   assign col_last_w = &col_q;

   popcount_tree #(.WORD_WIDTH(WORD_WIDTH)) u_pop (
      .data_i  (xor_w),
      .count_o (pop_w)
   );

   // Trial sequencer with registered bus command and status outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         row_q     <= '0;
         mode_q    <= MODE_DOUBLE;
         pattern_q <= '0;
         count_q   <= '0;
         col_q     <= '0;
         hcnt_q    <= '0;
         side_q    <= 1'b0;
         wait_q    <= 1'b0;
         addr_q    <= '0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         wdata_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         flip_q    <= '0;
`ifdef HAMMER_TEST_FLIP_LOG_EN
         ffcol_q   <= '0;
         ffmask_q  <= '0;
         fwords_q  <= '0;
`endif
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  row_q     <= cfg_row;
                  mode_q    <= cfg_mode;
                  pattern_q <= cfg_pattern;
                  count_q   <= cfg_count;
                  col_q     <= '0;
                  hcnt_q    <= '0;
                  side_q    <= 1'b0;
                  wait_q    <= 1'b0;
                  flip_q    <= '0;
                  busy_q    <= 1'b1;
                  done_q    <= 1'b0;
                  wr_q      <= 1'b1;
                  addr_q    <= mk_addr(cfg_row, '0);
                  wdata_q   <= cfg_pattern;
                  state_q   <= INIT;
`ifdef HAMMER_TEST_FLIP_LOG_EN
                  ffcol_q   <= '0;
                  ffmask_q  <= '0;
                  fwords_q  <= '0;
`endif
               end
            end
            INIT: begin
               if (accept_w) begin
                  col_q <= col_q + 1'b1;
                  if (col_last_w) begin
                     wr_q <= 1'b0;
                     rd_q <= 1'b1;
                     if (count_q == '0) begin
                        addr_q  <= mk_addr(row_q, '0);
                        state_q <= CHECK;
                     end else begin
                        addr_q  <= mk_addr(agg_a_w, '0);
                        side_q  <= 1'b1;
                        state_q <= HAMMER;
                     end
                  end else begin
                     addr_q <= mk_addr(row_q, col_q + 1'b1);
                  end
               end
            end
            HAMMER: begin
               if (rd_q && !avm_waitrequest) begin
                  rd_q   <= 1'b0;
                  wait_q <= 1'b1;
                  hcnt_q <= hcnt_q + 1'b1;
               end else if (wait_q && avm_readdatavalid) begin
                  wait_q <= 1'b0;
                  rd_q   <= 1'b1;
                  if (hcnt_q == count_q) begin
                     col_q   <= '0;
                     addr_q  <= mk_addr(row_q, '0);
                     state_q <= CHECK;
                  end else begin
                     addr_q <= mk_addr(side_q ? agg_b_w : agg_a_w, '0);
                     side_q <= ~side_q;
                  end
               end
            end
            CHECK: begin
               if (accept_w) begin
                  rd_q    <= 1'b0;
                  state_q <= CHECK_WAIT;
               end
            end
            CHECK_WAIT: begin
               if (avm_readdatavalid) begin
                  flip_q <= flip_d;
`ifdef HAMMER_TEST_FLIP_LOG_EN
                  if (xor_w != '0) begin
                     fwords_q <= fwords_q + 1'b1;
                     if (ffmask_q == '0) begin
                        ffcol_q  <= col_q;
                        ffmask_q <= xor_w;
                     end
                  end
`endif
                  if (col_last_w) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     col_q   <= col_q + 1'b1;
                     rd_q    <= 1'b1;
                     addr_q  <= mk_addr(row_q, col_q + 1'b1);
                     state_q <= CHECK;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign avm_address   = addr_q;
   assign avm_read      = rd_q;
   assign avm_write     = wr_q;
   assign avm_writedata = wdata_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign flip_count    = flip_q;
`ifdef HAMMER_TEST_FLIP_LOG_EN
   assign first_flip_col  = ffcol_q;
   assign first_flip_mask = ffmask_q;
   assign flip_words      = fwords_q;
`endif

endmodule
